// File: rtl/sm_bus_matrix_pkg.sv
// Shared constants and helpers for the sm_bus_matrix interconnect.
// Default memory map: slave 0 = GPIO window, which shadows the RAM window of slave 1.
package sm_bus_matrix_pkg;

  localparam int MST_N     = 2;
  localparam int SLV_N_DEF = 4;

  // Slave k occupies bits [32k+31:32k], so slave 0 is the rightmost entry.
  localparam logic [32*SLV_N_DEF-1:0] SLV_BASE_DEF = {
    32'h0002_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_BEB0
  };
  localparam logic [32*SLV_N_DEF-1:0] SLV_MASK_DEF = {
    32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FFF0
  };

  function automatic logic addr_match(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/sm_bus_matrix_if.sv
// Bus bundle between the two masters, the matrix and the SLV_N slaves.
// The matrix connects through the slave modport; the surrounding SoC uses master.
interface sm_bus_if #(
  parameter int SLV_N = 4
);
  logic [1:0]          m_req;
  logic [1:0]          m_we;
  logic [63:0]         m_addr;
  logic [63:0]         m_wdata;
  logic [1:0]          m_gnt;
  logic [1:0]          m_rvalid;
  logic [63:0]         m_rdata;
  logic [1:0]          m_err;
  logic [SLV_N-1:0]    s_req;
  logic [SLV_N-1:0]    s_we;
  logic [32*SLV_N-1:0] s_addr;
  logic [32*SLV_N-1:0] s_wdata;
  logic [32*SLV_N-1:0] s_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata, s_rdata,
    input  m_gnt, m_rvalid, m_rdata, m_err, s_req, s_we, s_addr, s_wdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, s_rdata,
    output m_gnt, m_rvalid, m_rdata, m_err, s_req, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/sm_bus_decode.sv
// Combinational address decode: one-hot slave select plus unmapped flag.
// Overlapping windows resolve to the lowest slave index.
module sm_bus_decode
  import sm_bus_matrix_pkg::*;
#(
  parameter int                  SLV_N    = SLV_N_DEF,
  parameter logic [32*SLV_N-1:0] SLV_BASE = SLV_BASE_DEF,
  parameter logic [32*SLV_N-1:0] SLV_MASK = SLV_MASK_DEF
) (
  input  logic [31:0]      addr_i,
  output logic [SLV_N-1:0] sel_o,
  output logic             unmapped_o
);

  always_comb begin
    sel_o      = '0;
    unmapped_o = 1'b1;
    // Walk downwards so the lowest matching index is the one left standing.
    for (int k = SLV_N - 1; k >= 0; k--) begin
      if (addr_match(addr_i, SLV_BASE[32*k +: 32], SLV_MASK[32*k +: 32])) begin
        sel_o      = '0;
        sel_o[k]   = 1'b1;
        unmapped_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sm_bus_matrix.sv
// Two-master, SLV_N-slave data bus matrix with per-slave round-robin arbitration.
// Optional first-fault capture (err_addr/err_valid) when SM_MATRIX_ERR_CAPTURE_EN is defined.
module sm_bus_matrix
  import sm_bus_matrix_pkg::*;
#(
  parameter int                  SLV_N    = SLV_N_DEF,
  parameter logic [32*SLV_N-1:0] SLV_BASE = SLV_BASE_DEF,
  parameter logic [32*SLV_N-1:0] SLV_MASK = SLV_MASK_DEF
) (
  input  logic     clk,
  input  logic     rst,
  sm_bus_if.slave  bus
`ifdef SM_MATRIX_ERR_CAPTURE_EN
  ,
  output logic [31:0] err_addr,
  output logic        err_valid
`endif
);

  logic [SLV_N-1:0] sel [MST_N];
  logic [MST_N-1:0] unm;
  logic [SLV_N-1:0] hit0, hit1, g0, g1, rr_q, rr_d;
  logic [MST_N-1:0] gnt, rvalid_d, rvalid_q, err_d, err_q;
  logic [31:0]      rd0, rd1;
  logic [63:0]      rdata_d, rdata_q;

  for (genvar i = 0; i < MST_N; i++) begin : g_dec
    sm_bus_decode #(
      .SLV_N   (SLV_N),
      .SLV_BASE(SLV_BASE),
      .SLV_MASK(SLV_MASK)
    ) u_dec (
      .addr_i    (bus.m_addr[32*i +: 32]),
      .sel_o     (sel[i]),
      .unmapped_o(unm[i])
    );
  end

  assign hit0 = sel[0] & {SLV_N{bus.m_req[0] & ~rst}};
  assign hit1 = sel[1] & {SLV_N{bus.m_req[1] & ~rst}};

  always_comb begin
    g0   = hit0;
    g1   = hit1;
    rr_d = rr_q;
    for (int k = 0; k < SLV_N; k++) begin
      if (hit0[k] && hit1[k]) begin
        g0[k]   = ~rr_q[k];
        g1[k]   = rr_q[k];
        rr_d[k] = ~rr_q[k];
      end
    end
  end

  always_comb begin
    bus.s_req   = g0 | g1;
    bus.s_we    = '0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    rd0         = '0;
    rd1         = '0;
    for (int k = 0; k < SLV_N; k++) begin
      if (g1[k]) begin
        bus.s_we[k]             = bus.m_we[1];
        bus.s_addr[32*k +: 32]  = bus.m_addr[63:32];
        bus.s_wdata[32*k +: 32] = bus.m_wdata[63:32];
      end else begin
        bus.s_we[k]             = g0[k] & bus.m_we[0];
        bus.s_addr[32*k +: 32]  = bus.m_addr[31:0];
        bus.s_wdata[32*k +: 32] = bus.m_wdata[31:0];
      end
      rd0 = rd0 | ({32{g0[k]}} & bus.s_rdata[32*k +: 32]);
      rd1 = rd1 | ({32{g1[k]}} & bus.s_rdata[32*k +: 32]);
    end
  end

  // Unmapped accesses are granted at once; rd0/rd1 are zero for them since no slave is selected.
  assign gnt[0]   = bus.m_req[0] & ~rst & (unm[0] | (|g0));
  assign gnt[1]   = bus.m_req[1] & ~rst & (unm[1] | (|g1));
  assign rvalid_d = gnt & ~bus.m_we;
  assign err_d    = gnt & unm;
  assign rdata_d  = {rvalid_d[1] ? rd1 : rdata_q[63:32],
                     rvalid_d[0] ? rd0 : rdata_q[31:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      rr_q     <= rr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.m_gnt    = gnt;
  assign bus.m_rvalid = rvalid_q;
  assign bus.m_err    = err_q;
  assign bus.m_rdata  = rdata_q;

`ifdef SM_MATRIX_ERR_CAPTURE_EN
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_valid_q, err_valid_d;

  always_comb begin
    err_addr_d  = err_addr_q;
    err_valid_d = err_valid_q;
    if (!err_valid_q && (|err_d)) begin
      err_valid_d = 1'b1;
      err_addr_d  = err_d[0] ? bus.m_addr[31:0] : bus.m_addr[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr_q  <= '0;
      err_valid_q <= 1'b0;
    end else begin
      err_addr_q  <= err_addr_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_valid = err_valid_q;
`endif

endmodule

// File: tb/tb_sm_bus_matrix.sv
// Scoreboard bench for sm_bus_matrix: stimulus pushes expected responses, a negedge monitor pops them.
// Honours SM_MATRIX_ERR_CAPTURE_EN when the same define is given to the whole build.
module tb_sm_bus_matrix;

  localparam int N = 4;

  typedef struct {
    logic        rv;
    logic        er;
    logic [31:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sbq [2][$];

  always #5 clk = ~clk;

  sm_bus_if #(.SLV_N(N)) bus ();

`ifdef SM_MATRIX_ERR_CAPTURE_EN
  logic [31:0] err_addr;
  logic        err_valid;
  sm_bus_matrix #(.SLV_N(N)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_addr(err_addr), .err_valid(err_valid)
  );
`else
  sm_bus_matrix #(.SLV_N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  // Slave model: each slave returns its address XOR a slave-specific tag.
  function automatic logic [31:0] pat(input int k);
    return 32'hA5A5_0000 | (32'(k) << 4);
  endfunction

  always_comb begin
    bus.s_rdata = '0;
    for (int k = 0; k < N; k++) bus.s_rdata[32*k +: 32] = bus.s_addr[32*k +: 32] ^ pat(k);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic push(input int m, input logic rv, input logic er, input logic [31:0] rd);
    exp_t e;
    e.rv = rv;
    e.er = er;
    e.rd = rd;
    sbq[m].push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (bus.m_rvalid[i] || bus.m_err[i]) begin
        total++;
        if (sbq[i].size() == 0) begin
          bad++;
          $display("FAIL resp_m%0d unexpected rvalid=%b err=%b", i, bus.m_rvalid[i], bus.m_err[i]);
        end else begin
          e = sbq[i].pop_front();
          if (bus.m_rvalid[i] !== e.rv || bus.m_err[i] !== e.er ||
              (e.rv && bus.m_rdata[32*i +: 32] !== e.rd)) begin
            bad++;
            $display("FAIL resp_m%0d got rv=%b err=%b rd=%h want rv=%b err=%b rd=%h",
                     i, bus.m_rvalid[i], bus.m_err[i], bus.m_rdata[32*i +: 32], e.rv, e.er, e.rd);
          end
        end
      end
    end
  end

  task automatic drv(input logic [1:0] req, input logic [1:0] we,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] w0 = 32'h0, input logic [31:0] w1 = 32'h0);
    bus.m_req   = req;
    bus.m_we    = we;
    bus.m_addr  = {a1, a0};
    bus.m_wdata = {w1, w0};
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle and check the combinational grant/strobe response.
  task automatic cyc(input string nm, input logic [1:0] req, input logic [1:0] we,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [1:0] egnt, input logic [N-1:0] esreq,
                     input logic [31:0] w0 = 32'h0, input logic [31:0] w1 = 32'h0);
    drv(req, we, a0, a1, w0, w1);
    #3;
    chk({nm, "_gnt"}, 64'(bus.m_gnt), 64'(egnt));
    chk({nm, "_sreq"}, 64'(bus.s_req), 64'(esreq));
  endtask

  logic [31:0] ca0 [5] = '{32'h100, 32'h104, 32'h104, 32'h108, 32'h108};
  logic [31:0] ca1 [5] = '{32'h200, 32'h200, 32'h204, 32'h204, 32'h0};
  logic [1:0]  creq[5] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
  logic [1:0]  cgnt[5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

  initial begin
    rst = 1'b1;
    drv(2'b11, 2'b00, 32'h100, 32'h200);
    nxt();
    nxt();
    #3;
    chk("rst_gnt", 64'(bus.m_gnt), 64'h0);
    chk("rst_sreq", 64'(bus.s_req), 64'h0);
    chk("rst_rvalid", 64'(bus.m_rvalid), 64'h0);
    chk("rst_rdata", bus.m_rdata, 64'h0);
    chk("rst_err", 64'(bus.m_err), 64'h0);
`ifdef SM_MATRIX_ERR_CAPTURE_EN
    chk("rst_err_addr", 64'(err_addr), 64'h0);
    chk("rst_err_valid", 64'(err_valid), 64'h0);
`endif
    nxt();
    rst = 1'b0;

    // Map check: GPIO window on slave 0.
    push(0, 1'b1, 1'b0, 32'h0000_BEB4 ^ pat(0));
    cyc("map", 2'b01, 2'b00, 32'h0000_BEB4, 32'h0, 2'b01, 4'b0001);
    chk("map_saddr", 64'(bus.s_addr[31:0]), 64'h0000_BEB4);
    nxt();
    drv(2'b00, 2'b00, 32'h0, 32'h0);
    nxt();
    #3;
    chk("hold_rvalid", 64'(bus.m_rvalid), 64'h0);
    chk("hold_rdata", 64'(bus.m_rdata[31:0]), 64'(32'h0000_BEB4 ^ pat(0)));
    nxt();

    // Parallel: m0 writes RAM, m1 reads slave 2.
    push(1, 1'b1, 1'b0, 32'h0001_0000 ^ pat(2));
    cyc("par", 2'b11, 2'b01, 32'h0000_0010, 32'h0001_0000, 2'b11, 4'b0110, 32'hDEAD_BEEF);
    chk("par_swe", 64'(bus.s_we), 64'h2);
    chk("par_swdata", 64'(bus.s_wdata[63:32]), 64'hDEAD_BEEF);
    chk("par_saddr1", 64'(bus.s_addr[63:32]), 64'h10);
    chk("par_saddr2", 64'(bus.s_addr[95:64]), 64'h0001_0000);
    nxt();

    // Conflict on RAM: losers hold their request, grants alternate.
    for (int c = 0; c < 5; c++) begin
      if (cgnt[c][0]) push(0, 1'b1, 1'b0, ca0[c] ^ pat(1));
      if (cgnt[c][1]) push(1, 1'b1, 1'b0, ca1[c] ^ pat(1));
      cyc($sformatf("conf%0d", c), creq[c], 2'b00, ca0[c], ca1[c], cgnt[c], 4'b0010);
      nxt();
    end

    // Unmapped read then unmapped write.
    push(1, 1'b1, 1'b1, 32'h0);
    cyc("unm_rd", 2'b10, 2'b00, 32'h0, 32'hF000_0000, 2'b10, 4'b0000);
    nxt();
    push(0, 1'b0, 1'b1, 32'h0);
    cyc("unm_wr", 2'b01, 2'b01, 32'hE000_0000, 32'h0, 2'b01, 4'b0000);
    chk("unm_wr_swe", 64'(bus.s_we), 64'h0);
`ifdef SM_MATRIX_ERR_CAPTURE_EN
    chk("cap_addr", 64'(err_addr), 64'hF000_0000);
    chk("cap_valid", 64'(err_valid), 64'h1);
`endif
    nxt();
    drv(2'b00, 2'b00, 32'h0, 32'h0);
    #3;
`ifdef SM_MATRIX_ERR_CAPTURE_EN
    chk("cap_sticky_addr", 64'(err_addr), 64'hF000_0000);
    chk("cap_sticky_valid", 64'(err_valid), 64'h1);
`endif
    nxt();

    // Decode boundaries.
    push(0, 1'b1, 1'b0, 32'h0000_BEBF ^ pat(0));
    push(1, 1'b1, 1'b0, 32'h0000_BEC0 ^ pat(1));
    cyc("edge_a", 2'b11, 2'b00, 32'h0000_BEBF, 32'h0000_BEC0, 2'b11, 4'b0011);
    nxt();
    push(0, 1'b1, 1'b1, 32'h0);
    push(1, 1'b1, 1'b0, 32'h0002_FFFC ^ pat(3));
    cyc("edge_b", 2'b11, 2'b00, 32'h0003_0000, 32'h0002_FFFC, 2'b11, 4'b1000);
    nxt();

    // Reset mid-operation: rr[1] is flipped to 1 first, reset must return it to 0.
    push(0, 1'b1, 1'b0, 32'h300 ^ pat(1));
    cyc("pre_rst", 2'b11, 2'b00, 32'h300, 32'h400, 2'b01, 4'b0010);
    nxt();
    rst = 1'b1;
    cyc("mid_rst", 2'b01, 2'b00, 32'h300, 32'h0, 2'b00, 4'b0000);
    nxt();
    rst = 1'b0;
    push(0, 1'b1, 1'b0, 32'h500 ^ pat(1));
    cyc("post_rst", 2'b11, 2'b00, 32'h500, 32'h600, 2'b01, 4'b0010);
    nxt();
    drv(2'b00, 2'b00, 32'h0, 32'h0);
    nxt();
    nxt();
    nxt();

    chk("sb_empty_m0", 64'(sbq[0].size()), 64'h0);
    chk("sb_empty_m1", 64'(sbq[1].size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
